// File: rtl/ldst_pkg.sv
// ldst_pkg: shared opcodes, FSM state encoding and default widths for ldst_deref
package ldst_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_ADDR_W = 16;
  localparam logic [4:0] OP_LOAD  = 5'b10000;
  localparam logic [4:0] OP_STORE = 5'b10001;
  typedef enum logic [2:0] {IDLE, FETCH, OPND, EXEC, MEM, WB} state_t;
  function automatic logic is_mem_op(input logic [4:0] op);
    return op == OP_LOAD || op == OP_STORE;
  endfunction
endpackage

// File: rtl/ldst_deref.sv
// ldst_deref: operand fetch, ALU/memory dispatch and writeback sequencer; LDST_DEREF_ALIGN_CHECK_EN adds word-alignment faulting
module ldst_deref
  import ldst_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [REG_AW-1:0] rsrc1,
  input  logic [REG_AW-1:0] rsrc2,
  input  logic [REG_AW-1:0] rdst,
  output logic              regread,
  output logic [REG_AW-1:0] raddr1,
  output logic [REG_AW-1:0] raddr2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  output logic              regwrite,
  output logic [REG_AW-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              alu_start,
  output logic [4:0]        alu_op,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_out,
  output logic              done,
  output logic              err
);
  state_t state;
  logic [4:0] op;
  logic [REG_AW-1:0] dst;
  logic [DATA_W-1:0] res;
  logic misal;
  assign mem_addr = a[ADDR_W-1:0];
  assign mem_wdata = b;
`ifdef LDST_DEREF_ALIGN_CHECK_EN
  // rdata1 is the address being latched into a this cycle
  assign misal = is_mem_op(op) && (rdata1[1:0] != 2'b00);
  always_ff @(posedge clk)
    err <= !rst && state == OPND && misal;
`else
  assign misal = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      regread <= 1'b0;
      raddr1 <= '0;
      raddr2 <= '0;
      regwrite <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      alu_start <= 1'b0;
      alu_op <= '0;
      a <= '0;
      b <= '0;
      done <= 1'b0;
      op <= '0;
      dst <= '0;
      res <= '0;
    end else begin
      regread <= 1'b0;
      regwrite <= 1'b0;
      alu_start <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          op <= opcode;
          dst <= rdst;
          raddr1 <= rsrc1;
          raddr2 <= rsrc2;
          regread <= 1'b1;
          in_ready <= 1'b0;
          state <= FETCH;
        end
        FETCH: state <= OPND;
        OPND: begin
          a <= rdata1;
          b <= rdata2;
          if (misal) begin
            done <= 1'b1;
            in_ready <= 1'b1;
            state <= IDLE;
          end else if (is_mem_op(op)) begin
            mem_req <= 1'b1;
            mem_we <= op == OP_STORE;
            state <= MEM;
          end else begin
            alu_start <= 1'b1;
            alu_op <= op;
            state <= EXEC;
          end
        end
        EXEC: if (alu_done) begin
          res <= alu_out;
          state <= WB;
        end
        MEM: if (mem_ack) begin
          mem_req <= 1'b0;
          mem_we <= 1'b0;
          if (op == OP_STORE) begin
            done <= 1'b1;
            in_ready <= 1'b1;
            state <= IDLE;
          end else begin
            res <= mem_rdata;
            state <= WB;
          end
        end
        WB: begin
          regwrite <= dst != '0;
          waddr <= dst;
          wdata <= res;
          done <= 1'b1;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ldst_deref.sv
// tb_ldst_deref: directed transactions against a latency/behaviour model with per-cycle output checks
module tb_ldst_deref;
  import ldst_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, in_ready;
  logic [4:0] opcode = '0, rsrc1 = '0, rsrc2 = '0, rdst = '0;
  logic regread, regwrite, mem_req, mem_we, mem_ack, alu_start, alu_done, done, err;
  logic [4:0] raddr1, raddr2, waddr, alu_op;
  logic [31:0] rdata1 = '0, rdata2 = '0, wdata, mem_wdata, mem_rdata, a, b, alu_out;
  logic [15:0] mem_addr;
  ldst_deref dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .rsrc1(rsrc1), .rsrc2(rsrc2), .rdst(rdst), .regread(regread), .raddr1(raddr1),
    .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2), .regwrite(regwrite), .waddr(waddr),
    .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .alu_start(alu_start),
    .alu_op(alu_op), .a(a), .b(b), .alu_done(alu_done), .alu_out(alu_out), .done(done), .err(err)
  );
  int cyc = 0, total = 0, bad = 0;
  int e_issue = -1000, e_lat = 0, e_w = 0, e_kind = 0, done_k = -1, lat_alu = 1, mwait = 0, acnt = 0, mcnt = 0, k;
  logic e_wr = 1'b0;
  logic [4:0] e_waddr = '0, e_op = '0, e_s1 = '0, e_s2 = '0;
  logic [31:0] e_wdata = '0, e_addr = '0, e_mdata = '0;
  bit chk_en = 0, stray_ack = 0, stray_done = 0, mem_op;
  logic [31:0] regs [32];
  logic [31:0] mem [256];
  function automatic logic [31:0] alu_fn(input logic [4:0] o, input logic [31:0] x, y);
    return o == 5'd0 ? x + y : x ^ y;
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (regread) begin
      rdata1 <= regs[raddr1];
      rdata2 <= regs[raddr2];
    end
    if (regwrite) regs[waddr] <= wdata;
  end
  always @(posedge clk) acnt <= alu_start ? lat_alu : (acnt > 0 ? acnt - 1 : 0);
  assign alu_done = (acnt == 1) || stray_done;
  assign alu_out = alu_fn(alu_op, a, b);
  always @(posedge clk) begin
    mcnt <= (mem_req && !mem_ack) ? mcnt + 1 : 0;
    if (mem_req && mem_ack && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end
  assign mem_ack = (mem_req && mcnt == mwait) || stray_ack;
  assign mem_rdata = mem[mem_addr[7:0]];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", n, act, exp, cyc);
    end
  endtask
  // k counts cycles since the accepting edge; all expectations follow from the latency rules
  always @(negedge clk) if (chk_en) begin
    k = cyc - e_issue;
    mem_op = e_kind == 1 || e_kind == 2;
    if (done) done_k = k;
    chk("in_ready", in_ready, !(k >= 0 && k < e_lat));
    chk("done", done, k == e_lat);
    chk("err", err, e_kind == 3 && k == 2);
    chk("regread", regread, k == 0);
    if (regread) begin
      chk("raddr1", raddr1, e_s1);
      chk("raddr2", raddr2, e_s2);
    end
    chk("alu_start", alu_start, e_kind == 0 && k == 2);
    if (alu_start) chk("alu_op", alu_op, e_op);
    chk("mem_req", mem_req, mem_op && k >= 2 && k <= 2 + e_w);
    if (mem_req) begin
      chk("mem_we", mem_we, e_kind == 2);
      chk("mem_addr", mem_addr, e_addr);
      if (e_kind == 2) chk("mem_wdata", mem_wdata, e_mdata);
    end
    chk("regwrite", regwrite, e_wr && k == e_lat);
    if (regwrite) begin
      chk("waddr", waddr, e_waddr);
      chk("wdata", wdata, e_wdata);
    end
  end
  task automatic accept(input logic [4:0] o, input logic [4:0] s1, s2, d);
    logic [31:0] av, bv;
    av = regs[s1];
    bv = regs[s2];
    e_op = o; e_s1 = s1; e_s2 = s2; e_waddr = d; e_w = mwait;
    e_addr = {16'h0, av[15:0]};
    e_mdata = bv;
    e_wr = d != 5'd0;
    if (o == OP_LOAD) begin
      e_kind = 1; e_lat = 4 + mwait; e_wdata = mem[av[7:0]];
    end else if (o == OP_STORE) begin
      e_kind = 2; e_lat = 3 + mwait; e_wr = 1'b0;
    end else begin
      e_kind = 0; e_lat = 4 + lat_alu; e_wdata = alu_fn(o, av, bv);
    end
`ifdef LDST_DEREF_ALIGN_CHECK_EN
    if (is_mem_op(o) && av[1:0] != 2'b00) begin
      e_kind = 3; e_lat = 2; e_wr = 1'b0;
    end
`endif
    done_k = -1;
    e_issue = cyc;
  endtask
  task automatic run(input logic [4:0] o, input logic [4:0] s1, s2, d);
    @(posedge clk); #1;
    opcode = o; rsrc1 = s1; rsrc2 = s2; rdst = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    accept(o, s1, s2, d);
    repeat (e_lat + 2) @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    regs[1] = 5; regs[2] = 7; regs[4] = 32'h40; regs[8] = 32'h10; regs[9] = 32'h55;
    regs[10] = 32'h90; regs[11] = 32'h09; regs[12] = 32'h42;
    mem[8'h40] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst in_ready", in_ready, 1);
    chk("rst regread", regread, 0);
    chk("rst regwrite", regwrite, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst alu_start", alu_start, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst a", a, 0);
    chk("rst b", b, 0);
    chk("rst wdata", wdata, 0);
    chk_en = 1;
    lat_alu = 2;
    run(5'b00000, 5'd1, 5'd2, 5'd3);
    chk("add latency", done_k, 6);
    chk("add r3", regs[3], 12);
    mwait = 0;
    run(OP_LOAD, 5'd4, 5'd0, 5'd6);
    chk("load latency", done_k, 4);
    chk("load r6", regs[6], 32'hDEADBEEF);
    mwait = 3;
    run(OP_STORE, 5'd8, 5'd9, 5'd7);
    chk("store latency", done_k, 6);
    chk("store mem", mem[8'h10], 32'h55);
    chk("store r7", regs[7], 0);
    lat_alu = 1;
    regs[0] = '0;
    run(5'b00000, 5'd10, 5'd11, 5'd0);
    chk("r0 latency", done_k, 5);
    chk("r0 kept", regs[0], 0);
    @(posedge clk); #1;
    stray_ack = 1; stray_done = 1;
    repeat (2) @(posedge clk);
    #1 stray_ack = 0; stray_done = 0;
    repeat (2) @(posedge clk);
    #1 mwait = 10;
    opcode = OP_STORE; rsrc1 = 5'd8; rsrc2 = 5'd11; rdst = 5'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    accept(OP_STORE, 5'd8, 5'd11, 5'd5);
    opcode = 5'b00000; rsrc1 = 5'd1; rsrc2 = 5'd2; rdst = 5'd3;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; e_issue = -1000;
    repeat (4) @(posedge clk);
    #1;
    chk("abort mem", mem[8'h10], 32'h55);
    chk("abort a", a, 0);
    chk("abort done", done_k, -1);
`ifdef LDST_DEREF_ALIGN_CHECK_EN
    mwait = 0;
    run(OP_LOAD, 5'd12, 5'd0, 5'd6);
    chk("misalign latency", done_k, 2);
    chk("misalign r6", regs[6], 32'hDEADBEEF);
`endif
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
